prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, assembles 32-bit
// little-endian instruction words, writes them to instruction memory, and
// holds the core in reset until a complete program is resident.
module prog_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    // Word index needs one extra bit so it can reach DEPTH after the last write.
    localparam int unsigned IDX_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [15:0]      n;
    logic [23:0]      hold;
    logic             xfer;
    logic [15:0]      hdr_len;

    // A byte moves only when the registered ready meets an incoming valid.
    assign xfer    = rx_valid & rx_ready;
    // Full header length as it will look once the high byte is taken.
    assign hdr_len = {rx_data, n[7:0]};

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN0;
            end
            S_LEN0: begin
                if (xfer) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (xfer) begin
                    if (hdr_len == 16'd0) begin
                        state_nxt = S_DONE;
                    end else if (hdr_len > 16'(DEPTH)) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // word_idx has already advanced past the word being written.
                if (mem_we && (16'(word_idx) == n)) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = S_LEN0;
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs (decoded from next state) plus header/assembly datapath.
    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            n         <= '0;
            hold      <= '0;
        end else begin
            rx_ready <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                        (state_nxt == S_LOAD);
            cpu_rst  <= (state_nxt != S_DONE);
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERR);
            mem_we   <= 1'b0;

            case (state)
                S_LEN0: begin
                    if (xfer) n[7:0] <= rx_data;
                end
                S_LEN1: begin
                    if (xfer) begin
                        n[15:8]  <= rx_data;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        hold     <= '0;
                    end
                end
                S_LOAD: begin
                    // Bytes arriving in the final write cycle are dropped.
                    if (xfer && (state_nxt == S_LOAD)) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: hold[7:0]   <= rx_data;
                            2'd1: hold[15:8]  <= rx_data;
                            2'd2: hold[23:16] <= rx_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= word_idx[ADDR_W-1:0];
                                mem_wdata <= {rx_data, hold};
                                word_idx  <= word_idx + IDX_W'(1);
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: directed loads, header edge cases,
// handshake gaps, mid-load reset and restart from DONE.
module tb_prog_loader;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    wr_t sb[$];
    int  tests    = 0;
    int  fails    = 0;
    int  we_count = 0;

    logic [31:0] prog [4] = '{32'h401181B3, 32'h00312233, 32'h00020463, 32'h001102B3};

    prog_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            we_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (1) begin
            @(negedge CLK);
            if (rx_ready === 1'b1) break;
            guard++;
            if (guard > 50) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: rx_ready stayed 0, expected 1 (byte 0x%02h)", b);
                break;
            end
        end
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 6'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready), 32'd0);
        check({tag, "_mem_we"},    32'(mem_we),   32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,     32'd0);
        check({tag, "_cpu_rst"},   32'(cpu_rst),  32'd1);
        check({tag, "_done"},      32'(done),     32'd0);
        check({tag, "_err"},       32'(err),      32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0, w1, w2;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Valid bytes in IDLE are not accepted.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) tick();
        rx_valid = 1'b0;
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_cpu_rst",  32'(cpu_rst),  32'd1);

        // N=4 continuous load; next word's first byte lands in each write cycle.
        pulse_start();
        check("len0_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) push_wr(i, prog[i]);
        for (int i = 0; i < 4; i++) send_word(prog[i], 1'b0);
        check("last_we",        32'(mem_we),  32'd1);
        check("last_we_cpurst", 32'(cpu_rst), 32'd1);
        check("last_we_done",   32'(done),    32'd0);
        tick();
        check("n4_done",     32'(done),     32'd1);
        check("n4_cpu_rst",  32'(cpu_rst),  32'd0);
        check("n4_rx_ready", 32'(rx_ready), 32'd0);
        check("n4_mem_we",   32'(mem_we),   32'd0);
        check("n4_writes",   32'(we_count), 32'd4);

        // Restart from DONE: outputs flip on the start edge.
        pulse_start();
        check("restart_done",     32'(done),     32'd0);
        check("restart_cpu_rst",  32'(cpu_rst),  32'd1);
        check("restart_rx_ready", 32'(rx_ready), 32'd1);

        // Empty program.
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick();
        check("n0_cpu_rst", 32'(cpu_rst),  32'd0);
        check("n0_done",    32'(done),     32'd1);
        check("n0_writes",  32'(we_count), 32'd4);

        // N=2 with random idle gaps on rx_valid.
        w0 = 32'hDEADBEEF;
        w1 = 32'h12345678;
        pulse_start();
        send_byte(8'h02, int'($urandom_range(0, 2)));
        send_byte(8'h00, int'($urandom_range(0, 2)));
        push_wr(0, w0);
        push_wr(1, w1);
        send_word(w0, 1'b1);
        send_word(w1, 1'b1);
        wait_done("n2_done");
        check("n2_writes", 32'(we_count), 32'd6);

        // N=3 interrupted by reset after two bytes of word 1.
        w0 = 32'hA5A5_0F0F;
        w1 = 32'h1122_3344;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        push_wr(0, w0);
        send_word(w0, 1'b0);
        send_byte(w1[7:0], 0);
        send_byte(w1[15:8], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) tick();
        rx_valid = 1'b0;
        check("midrst_writes", 32'(we_count), 32'd7);

        // Fresh N=1 load after the interrupted one.
        w2 = 32'hCAFEF00D;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        push_wr(0, w2);
        send_word(w2, 1'b0);
        wait_done("n1_done");
        check("n1_cpu_rst", 32'(cpu_rst),  32'd0);
        check("n1_writes",  32'(we_count), 32'd8);

        // N=65 exceeds DEPTH: sticky error until reset.
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        check("err_flag",     32'(err),      32'd1);
        check("err_cpu_rst",  32'(cpu_rst),  32'd1);
        check("err_rx_ready", 32'(rx_ready), 32'd0);
        check("err_done",     32'(done),     32'd0);
        pulse_start();
        tick();
        check("err_hold",          32'(err),      32'd1);
        check("err_hold_rx_ready", 32'(rx_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_rst_err",     32'(err),     32'd0);
        check("err_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("err_rst_done",    32'(done),    32'd0);
        repeat (2) tick();
        check("final_writes",  32'(we_count),  32'd8);
        check("sb_empty",      32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
